// File: rtl/text_pkg.sv
// Shared constants and types for the on-screen text renderer.
package text_pkg;

  localparam int CELL_W = 8;
  localparam int CELL_H = 8;
  localparam int DOT_W  = 5;
  localparam int DOT_H  = 7;

  typedef logic [5:0] glyph_t;

  localparam glyph_t GLYPH_BLANK = 6'd0;
  localparam glyph_t GLYPH_A     = 6'd1;
  localparam glyph_t GLYPH_0     = 6'd27;

  typedef enum logic [1:0] {
    TM_STATIC = 2'b00,
    TM_BLINK  = 2'b01,
    TM_TYPE   = 2'b10,
    TM_OFF    = 2'b11
  } text_mode_t;

endpackage

// File: rtl/font_rom_5x7.sv
// 5x7 glyph ROM: letters A-Z, digits 0-9, everything else blank.
// Output bit 4 is the leftmost dot column; row 7 is always dark.
module font_rom_5x7
  import text_pkg::*;
(
  input  glyph_t      code,
  input  logic [2:0]  row,
  output logic [4:0]  dots
);

  logic [34:0] glyph;

  // Full bitmap of the selected glyph, row 0 in the top five bits
  always_comb begin
    glyph = '0;
    case (code)
      GLYPH_A:          glyph = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
      GLYPH_A + 6'd1:   glyph = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b11110};
      GLYPH_A + 6'd2:   glyph = {5'b01110, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b01110};
      GLYPH_A + 6'd3:   glyph = {5'b11110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11110};
      GLYPH_A + 6'd4:   glyph = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
      GLYPH_A + 6'd5:   glyph = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
      GLYPH_A + 6'd6:   glyph = {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01111};
      GLYPH_A + 6'd7:   glyph = {5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
      GLYPH_A + 6'd8:   glyph = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      GLYPH_A + 6'd9:   glyph = {5'b00111, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b10010, 5'b01100};
      GLYPH_A + 6'd10:  glyph = {5'b10001, 5'b10010, 5'b10100, 5'b11000, 5'b10100, 5'b10010, 5'b10001};
      GLYPH_A + 6'd11:  glyph = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111};
      GLYPH_A + 6'd12:  glyph = {5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001};
      GLYPH_A + 6'd13:  glyph = {5'b10001, 5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001};
      GLYPH_A + 6'd14:  glyph = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
      GLYPH_A + 6'd15:  glyph = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
      GLYPH_A + 6'd16:  glyph = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10010, 5'b01101};
      GLYPH_A + 6'd17:  glyph = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001};
      GLYPH_A + 6'd18:  glyph = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
      GLYPH_A + 6'd19:  glyph = {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
      GLYPH_A + 6'd20:  glyph = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
      GLYPH_A + 6'd21:  glyph = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01010, 5'b00100};
      GLYPH_A + 6'd22:  glyph = {5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010};
      GLYPH_A + 6'd23:  glyph = {5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b01010, 5'b10001, 5'b10001};
      GLYPH_A + 6'd24:  glyph = {5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
      GLYPH_A + 6'd25:  glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11111};
      GLYPH_0:          glyph = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
      GLYPH_0 + 6'd1:   glyph = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      GLYPH_0 + 6'd2:   glyph = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
      GLYPH_0 + 6'd3:   glyph = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
      GLYPH_0 + 6'd4:   glyph = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
      GLYPH_0 + 6'd5:   glyph = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
      GLYPH_0 + 6'd6:   glyph = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
      GLYPH_0 + 6'd7:   glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
      GLYPH_0 + 6'd8:   glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
      GLYPH_0 + 6'd9:   glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
      default:          glyph = '0;
    endcase
  end

  // Pick one dot row; the spare row below the glyph stays dark
  always_comb begin
    dots = '0;
    if (int'(row) < DOT_H) dots = glyph[5 * (3'd6 - row) +: 5];
  end

endmodule

// File: rtl/text_overlay.sv
// Text line renderer: character buffer, two-stage pixel pipeline and
// frame-driven display modes (static, blink, typewriter reveal, off).
module text_overlay
  import text_pkg::*;
#(
  parameter int N_CHARS       = 16,
  parameter int SCALE_LOG2    = 1,
  parameter int X0            = 10,
  parameter int Y0            = 10,
  parameter int REVEAL_FRAMES = 8,
  parameter int BLINK_FRAMES  = 32
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       frame_start,
  input  logic                       wr_en,
  input  logic [$clog2(N_CHARS)-1:0] wr_addr,
  input  logic [5:0]                 wr_char,
  input  logic [1:0]                 mode,
  input  logic                       restart,
  output logic                       text_on,
  output logic                       reveal_done
);

  localparam int IDX_W     = $clog2(N_CHARS);
  localparam int IDX_SHIFT = $clog2(CELL_W) + SCALE_LOG2;
  localparam logic [12:0] RX_LIMIT = 13'(N_CHARS << IDX_SHIFT);
  localparam logic [10:0] RY_LIMIT = 11'(CELL_H << SCALE_LOG2);
  localparam int RC_W = $clog2(N_CHARS + 1);
  localparam logic [RC_W-1:0] REVEAL_ALL = RC_W'(N_CHARS);
  localparam int BF_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BF_W-1:0] BLINK_LAST = BF_W'(BLINK_FRAMES - 1);
  localparam int RF_W = $clog2(REVEAL_FRAMES + 1);
  localparam logic [RF_W-1:0] REVEAL_LAST = RF_W'(REVEAL_FRAMES - 1);

  glyph_t            buf_d [N_CHARS];
  glyph_t            buf_q [N_CHARS];
  logic [10:0]       rx, ry;
  logic              inside_d, inside_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [2:0]        col_d, col_q, row_d, row_q;
  glyph_t            code_d, code_q;
  logic [4:0]        dots;
  logic              dot_bit, visible;
  logic              text_on_d, text_on_q;
  text_mode_t        mode_cur, mode_q;
  logic [BF_W-1:0]   blink_cnt_d, blink_cnt_q;
  logic              blink_phase_d, blink_phase_q;
  logic [RF_W-1:0]   reveal_frm_d, reveal_frm_q;
  logic [RC_W-1:0]   reveal_cnt_d, reveal_cnt_q;
  logic              reveal_done_d, reveal_done_q;

  assign mode_cur    = text_mode_t'(mode);
  assign text_on     = text_on_q;
  assign reveal_done = reveal_done_q;

  // Next buffer contents: at most one slot replaced per cycle
  always_comb begin
    for (int i = 0; i < N_CHARS; i++) buf_d[i] = buf_q[i];
    if (wr_en) buf_d[wr_addr] = wr_char;
  end

  // Character buffer; stage 1 reads the pre-edge contents, so a colliding write shows a cycle later
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_CHARS; i++) buf_q[i] <= GLYPH_BLANK;
    end else begin
      for (int i = 0; i < N_CHARS; i++) buf_q[i] <= buf_d[i];
    end
  end

  // Map the screen pixel onto a character slot and a scaled cell position
  always_comb begin
    rx       = {1'b0, DrawX} - 11'(X0);
    ry       = {1'b0, DrawY} - 11'(Y0);
    inside_d = (DrawX >= 10'(X0)) && ({2'b00, rx} < RX_LIMIT) &&
               (DrawY >= 10'(Y0)) && (ry < RY_LIMIT);
    idx_d    = IDX_W'(rx >> IDX_SHIFT);
    col_d    = 3'(rx >> SCALE_LOG2);
    row_d    = 3'(ry >> SCALE_LOG2);
    code_d   = buf_q[idx_d];
  end

  // Stage 1: geometry and glyph code
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      inside_q <= 1'b0;
      idx_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      code_q   <= GLYPH_BLANK;
    end else begin
      inside_q <= inside_d;
      idx_q    <= idx_d;
      col_q    <= col_d;
      row_q    <= row_d;
      code_q   <= code_d;
    end
  end

  font_rom_5x7 u_font (
    .code (code_q),
    .row  (row_q),
    .dots (dots)
  );

  // Combine dot, bounds and the current mode's visibility rule
  always_comb begin
    dot_bit = 1'b0;
    if (int'(col_q) < DOT_W) dot_bit = dots[3'd4 - col_q];
    visible = 1'b0;
    case (mode_cur)
      TM_STATIC: visible = 1'b1;
      TM_BLINK:  visible = blink_phase_q;
      TM_TYPE:   visible = (RC_W'(idx_q) < reveal_cnt_q);
      default:   visible = 1'b0;
    endcase
    text_on_d = inside_q & dot_bit & visible;
  end

  // Stage 2: registered pixel output
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) text_on_q <= 1'b0;
    else          text_on_q <= text_on_d;
  end

  // Blink and reveal counters; the mode present this cycle decides who counts a frame pulse
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    reveal_frm_d  = reveal_frm_q;
    reveal_cnt_d  = reveal_cnt_q;
    if (mode_cur != TM_BLINK) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    if (mode_cur == TM_TYPE) begin
      if (restart || (mode_q != TM_TYPE)) begin
        reveal_frm_d = '0;
        reveal_cnt_d = '0;
      end else if (frame_start) begin
        if (reveal_frm_q == REVEAL_LAST) begin
          reveal_frm_d = '0;
          if (reveal_cnt_q != REVEAL_ALL) reveal_cnt_d = reveal_cnt_q + 1'b1;
        end else begin
          reveal_frm_d = reveal_frm_q + 1'b1;
        end
      end
    end
    reveal_done_d = (reveal_cnt_d == REVEAL_ALL);
  end

  // Mode history and frame counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q        <= TM_STATIC;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      reveal_frm_q  <= '0;
      reveal_cnt_q  <= '0;
      reveal_done_q <= 1'b0;
    end else begin
      mode_q        <= mode_cur;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      reveal_frm_q  <= reveal_frm_d;
      reveal_cnt_q  <= reveal_cnt_d;
      reveal_done_q <= reveal_done_d;
    end
  end

endmodule

// File: tb/tb_text_overlay.sv
// Directed self-checking bench for text_overlay with default parameters.
module tb_text_overlay;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [5:0] wr_char;
  logic [1:0] mode;
  logic       restart;
  logic       text_on;
  logic       reveal_done;

  int compared   = 0;
  int mismatched = 0;

  text_overlay #(
    .N_CHARS       (16),
    .SCALE_LOG2    (1),
    .X0            (10),
    .Y0            (10),
    .REVEAL_FRAMES (8),
    .BLINK_FRAMES  (32)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .mode        (mode),
    .restart     (restart),
    .text_on     (text_on),
    .reveal_done (reveal_done)
  );

  // Free-running pixel clock
  always #5 Clk = ~Clk;

  // Present a pixel and wait out the two pipeline stages
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
    @(negedge Clk);
    DrawX = x;
    DrawY = y;
    repeat (2) @(negedge Clk);
  endtask

  // One comparison: count it, flag and report a mismatch
  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkPixel(input string tag, input int x, input int y, input logic exp);
    applyStimulus(10'(x), 10'(y));
    checkOutput(tag, text_on, exp);
  endtask

  task automatic writeChar(input int addr, input int code);
    @(negedge Clk);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_char = 6'(code);
    @(negedge Clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulseFrames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    DrawX       = 10'd12;
    DrawY       = 10'd10;
    frame_start = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_char     = '0;
    mode        = 2'b00;
    restart     = 1'b0;

    // Reset state
    #12;
    checkOutput("reset_text_on", text_on, 1'b0);
    checkOutput("reset_reveal_done", reveal_done, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    checkPixel("blank_after_reset", 12, 10, 1'b0);

    // Static mode, 'A' in slot 0, row 0 sweep
    writeChar(0, 1);
    writeChar(1, 40);
    writeChar(2, 0);
    writeChar(4, 27);
    writeChar(15, 8);
    for (int x = 10; x <= 25; x++)
      checkPixel($sformatf("sweep_x%0d", x), x, 10, (x >= 12 && x <= 17));

    // Other rows of 'A' and the cell bottom edge
    checkPixel("A_row3_col0", 10, 16, 1'b1);
    checkPixel("A_row3_col4", 19, 16, 1'b1);
    checkPixel("A_row3_col5", 20, 16, 1'b0);
    checkPixel("A_row6_col0", 10, 22, 1'b1);
    checkPixel("A_row6_col1", 12, 22, 1'b0);
    checkPixel("A_row7", 10, 24, 1'b0);

    // Bounds
    checkPixel("left_x9", 9, 16, 1'b0);
    checkPixel("top_y9", 10, 9, 1'b0);
    checkPixel("bottom_y26", 10, 26, 1'b0);
    checkPixel("H_row3_col4", 259, 16, 1'b1);
    checkPixel("slot15_col7", 265, 16, 1'b0);
    checkPixel("right_x266", 266, 16, 1'b0);

    // Blank codes and a digit
    checkPixel("code40_col0", 26, 16, 1'b0);
    checkPixel("code40_col1", 28, 16, 1'b0);
    checkPixel("code0", 44, 16, 1'b0);
    checkPixel("digit0_col1", 76, 10, 1'b1);
    checkPixel("digit0_col0", 74, 10, 1'b0);

    // Blink mode
    @(negedge Clk);
    mode = 2'b01;
    checkPixel("blink_start_lit", 12, 10, 1'b1);
    pulseFrames(31);
    checkPixel("blink_31_lit", 12, 10, 1'b1);
    pulseFrames(1);
    checkPixel("blink_32_dark", 12, 10, 1'b0);
    pulseFrames(32);
    checkPixel("blink_64_lit", 12, 10, 1'b1);
    pulseFrames(32);
    checkPixel("blink_96_dark", 12, 10, 1'b0);
    @(negedge Clk);
    mode = 2'b00;
    checkPixel("blink_to_static_lit", 12, 10, 1'b1);
    @(negedge Clk);
    mode = 2'b11;
    checkPixel("mode_off_dark", 12, 10, 1'b0);

    // Typewriter mode with every slot 'A'
    for (int s = 0; s < 16; s++) writeChar(s, 1);
    @(negedge Clk);
    mode = 2'b10;
    checkPixel("type_start_slot0_dark", 12, 10, 1'b0);
    checkOutput("type_start_done", reveal_done, 1'b0);
    pulseFrames(7);
    checkPixel("type_7_slot0_dark", 12, 10, 1'b0);
    pulseFrames(1);
    checkPixel("type_8_slot0_lit", 12, 10, 1'b1);
    checkPixel("type_8_slot1_dark", 28, 10, 1'b0);
    pulseFrames(8);
    checkPixel("type_16_slot1_lit", 28, 10, 1'b1);
    checkPixel("type_16_slot2_dark", 44, 10, 1'b0);
    pulseFrames(104);
    checkPixel("type_120_slot14_lit", 236, 10, 1'b1);
    checkPixel("type_120_slot15_dark", 252, 10, 1'b0);
    checkOutput("type_120_done", reveal_done, 1'b0);
    pulseFrames(8);
    checkPixel("type_128_slot15_lit", 252, 10, 1'b1);
    checkOutput("type_128_done", reveal_done, 1'b1);
    pulseFrames(8);
    checkOutput("type_136_done_held", reveal_done, 1'b1);

    // Restart together with a counting frame pulse
    @(negedge Clk);
    restart     = 1'b1;
    frame_start = 1'b1;
    @(negedge Clk);
    restart     = 1'b0;
    frame_start = 1'b0;
    checkOutput("restart_done_clear", reveal_done, 1'b0);
    checkPixel("restart_slot0_dark", 12, 10, 1'b0);
    pulseFrames(7);
    checkPixel("restart_7_slot0_dark", 12, 10, 1'b0);
    pulseFrames(1);
    checkPixel("restart_8_slot0_lit", 12, 10, 1'b1);

    // Entering typewriter mode together with a frame pulse
    @(negedge Clk);
    mode = 2'b00;
    @(negedge Clk);
    mode        = 2'b10;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    pulseFrames(7);
    checkPixel("entry_7_slot0_dark", 12, 10, 1'b0);
    pulseFrames(1);
    checkPixel("entry_8_slot0_lit", 12, 10, 1'b1);

    // Write into slot 3 in the same cycle stage 1 reads it
    @(negedge Clk);
    mode = 2'b00;
    checkPixel("slot3_A_col1", 60, 10, 1'b1);
    @(negedge Clk);
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_char = 6'd8;
    @(negedge Clk);
    wr_en = 1'b0;
    @(negedge Clk);
    checkOutput("collision_old_glyph", text_on, 1'b1);
    @(negedge Clk);
    checkOutput("collision_new_glyph", text_on, 1'b0);
    checkPixel("slot3_H_col0", 58, 10, 1'b1);

    // Asynchronous reset mid-line
    checkPixel("pre_reset_lit", 12, 10, 1'b1);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("async_reset_text_on", text_on, 1'b0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    checkPixel("post_reset_slot0_clear", 12, 10, 1'b0);
    checkPixel("post_reset_slot3_clear", 58, 10, 1'b0);
    checkOutput("post_reset_done", reveal_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
